multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8: maximum MEM-state wait cycles without mem_ack before error.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instruction source holds valid instr.
REQ-005 instr  input  16  opcode = instr[15:12]; instr[11:0] is opaque to this block.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 mem_ack  input  1  data memory completes the current request.
REQ-008 mem_req  output  1  data memory request, held until mem_ack.
REQ-009 mem_we  output  1  1 = store, 0 = load; valid while mem_req=1.
REQ-010 alu_instr  output  2  instruction field to the ALU control decoder; always 2'b00.
REQ-011 alu_ctrl  output  3  ALU operation: 000 none, 001 ADD, 010 SUB, 011 AND, 100 OR.
REQ-012 reg_we  output  1  register-file write strobe.
REQ-013 pc_en  output  1  one-cycle PC advance strobe.
REQ-014 halted  output  1  block is stopped.
REQ-015 err  output  1  sticky error flag.
REQ-016 state_o  output  3  current state encoding, for debug.

Function
REQ-017 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
REQ-018 FETCH: instr_ready=1; on instr_valid&&instr_ready, latch instr and go to DECODE; otherwise stay.
REQ-019 DECODE: one cycle; opcode 0 (NOP) asserts pc_en and returns to FETCH; opcode F goes to HALT; opcodes 1-6 go to EXEC.
REQ-020 EXEC: one cycle; alu_ctrl = 001 for ADD(1), LD(5) and ST(6), 010 for SUB(2), 011 for AND(3), 100 for OR(4); alu_ctrl=000 in all other states.
REQ-021 From EXEC: opcodes 5 and 6 go to MEM; opcodes 1-4 go to WB.
REQ-022 MEM: mem_req=1 and mem_we=(opcode==6); on mem_ack, ST asserts pc_en and goes to FETCH, and LD goes to WB.
REQ-023 The MEM wait counter clears on MEM entry and increments each MEM cycle without mem_ack; when it reaches MEM_TIMEOUT, set err, drop mem_req next cycle and go to HALT.
REQ-024 mem_ack in the same cycle the counter reaches MEM_TIMEOUT counts as success, and err stays 0.
REQ-025 WB: one cycle with reg_we=1 and pc_en=1, then go to FETCH.
REQ-026 HALT: halted=1 and instr_ready=0; remain in HALT until reset.
REQ-027 Latency: ALU op = 4 cycles from handshake to the next FETCH; LD = 5 cycles plus mem wait; ST = 4 cycles plus mem wait.
REQ-028 mem_ack or instr_valid outside its consuming state is ignored.
REQ-029 Outputs are registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-030 Reset asserted: state=FETCH, latched instr=0, counter=0, err=0.
REQ-031 Outputs during reset: instr_ready=0, mem_req=0, mem_we=0, reg_we=0, pc_en=0, halted=0, alu_ctrl=000, alu_instr=00.
REQ-032 Reset asserted mid-operation (e.g. in MEM) immediately deasserts mem_req and abandons the instruction, with no pc_en.

Configuration
REQ-033 Macro MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN defined: opcodes 7-E in DECODE go to TRAP; TRAP sets err=1 and halted=1 and holds until reset.
REQ-034 Macro MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN undefined: opcodes 7-E execute as NOP (pc_en pulse, return to FETCH), TRAP is unreachable, and err is set only by timeout.

Verification
REQ-035 instr=16'h1000 accepted -> alu_ctrl=001 in EXEC; reg_we=1 and pc_en=1 exactly 3 cycles after the handshake; back to FETCH.
REQ-036 instr=16'h5000 with mem_ack after 2 wait cycles -> mem_req high 3 cycles, mem_we=0, then WB with reg_we=1.
REQ-037 instr=16'h6000 with mem_ack never asserted, MEM_TIMEOUT=8 -> err=1, state_o=5, halted=1; mem_ack at wait cycle 8 instead -> err=0.
REQ-038 instr=16'h9000 -> with the macro: state_o=6, err=1; without the macro: pc_en pulse and return to FETCH.
REQ-039 rst_n low during MEM for LD -> mem_req=0 asynchronously; after release, state_o=0 and instr_ready=1.
REQ-040 instr=16'hF000 -> halted=1; subsequent instr_valid is never accepted (instr_ready=0).

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with a memory-wait timeout.
// Optional: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN sends opcodes 7-E to a sticky TRAP state.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  alu_instr,
  output logic [2:0]  alu_ctrl,
  output logic        reg_we,
  output logic        pc_en,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state_o
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    op_q, op_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_nx;
  logic          st_done_q, st_done_nx;
  logic          active_q;
  logic          decode_nop;
  logic          unused_operand;

  assign unused_operand = ^instr[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      op_q      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      st_done_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      cnt       <= cnt_nx;
      err       <= err_nx;
      st_done_q <= st_done_nx;
      active_q  <= 1'b1;
    end
  end

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  assign decode_nop = (op_q == 4'h0);
`else
  assign decode_nop = (op_q == 4'h0) || (op_q inside {[4'h7:4'hE]});
`endif

  always_comb begin
    state_nx   = state;
    op_nx      = op_q;
    cnt_nx     = '0;
    err_nx     = err;
    st_done_nx = 1'b0;
    case (state)
      FETCH: begin
        if (instr_valid && instr_ready) begin
          op_nx    = instr[15:12];
          state_nx = DECODE;
        end
      end
      DECODE: begin
        case (op_q)
          4'h0: state_nx = FETCH;
          4'hF: state_nx = HALT;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_nx = EXEC;
          default: begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            state_nx = TRAP;
            err_nx   = 1'b1;
`else
            state_nx = FETCH;
`endif
          end
        endcase
      end
      EXEC: state_nx = (op_q == 4'h5 || op_q == 4'h6) ? MEM : WB;
      MEM: begin
        // An ack in the cycle the count hits the limit still wins over the timeout.
        if (mem_ack) begin
          if (op_q == 4'h6) begin
            state_nx   = FETCH;
            st_done_nx = 1'b1;
          end else begin
            state_nx = WB;
          end
        end else if (cnt == TMO) begin
          state_nx = HALT;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      TRAP:    state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    alu_ctrl = '0;
    if (state == EXEC) begin
      case (op_q)
        4'h1, 4'h5, 4'h6: alu_ctrl = 3'b001;
        4'h2:             alu_ctrl = 3'b010;
        4'h3:             alu_ctrl = 3'b011;
        4'h4:             alu_ctrl = 3'b100;
        default:          alu_ctrl = '0;
      endcase
    end
  end

  // The store's PC advance is registered so mem_ack never reaches pc_en combinationally.
  assign instr_ready = active_q && (state == FETCH);
  assign mem_req     = (state == MEM);
  assign mem_we      = (state == MEM) && (op_q == 4'h6);
  assign alu_instr   = '0;
  assign reg_we      = (state == WB);
  assign pc_en       = ((state == DECODE) && decode_nop) || (state == WB) || st_done_q;
  assign halted      = (state == HALT) || (state == TRAP);
  assign state_o     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction cycle model builds the
// expected output trace from opcode, memory wait and timeout rules.
module tb_multicycle_control;

  localparam int unsigned T = 8;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we;
  logic [1:0]  alu_instr;
  logic [2:0]  alu_ctrl;
  logic        reg_we, pc_en, halted, err;
  logic [2:0]  state_o;
  logic [12:0] outvec;

  multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .alu_instr(alu_instr), .alu_ctrl(alu_ctrl), .reg_we(reg_we), .pc_en(pc_en),
    .halted(halted), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign outvec = {state_o, instr_ready, mem_req, mem_we, alu_ctrl, reg_we, pc_en, halted, err};

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic        ack;
    logic [12:0] exp;
  } step_t;

  step_t prog[$];
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  int unsigned ncyc  = 0;
  bit          m_err, m_pend, m_stop;
  logic [2:0]  m_hst;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [2:0] st, input logic rdy, input logic req,
                                     input logic we, input logic [2:0] alu, input logic rwe,
                                     input logic pce, input logic hlt, input logic er);
    return {st, rdy, req, we, alu, rwe, pce, hlt, er};
  endfunction

  task automatic push(input logic v, input logic [15:0] i, input logic a, input logic [12:0] e);
    step_t s;
    s.valid = v; s.instr = i; s.ack = a; s.exp = e;
    prog.push_back(s);
  endtask

  // Non-consuming cycle: random valid/instr/ack noise must be ignored.
  task automatic push_noise(input logic [12:0] e);
    push(1'($urandom), 16'($urandom), 1'($urandom), e);
  endtask

  task automatic push_fetch(input logic v, input logic [15:0] i);
    push(v, i, 1'($urandom), mk(3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, m_pend, 1'b0, m_err));
    m_pend = 1'b0;
  endtask

  task automatic gen_op(input logic [3:0] op, input int unsigned d, input int unsigned idle);
    logic illegal, nop_like;
    logic [2:0] alu;
    int unsigned n;
    if (m_stop) return;
    for (int unsigned i = 0; i < idle; i++) push_fetch(1'b0, 16'($urandom));
    push_fetch(1'b1, {op, 12'($urandom)});
    illegal  = (op >= 4'h7) && (op <= 4'hE);
    nop_like = (op == 4'h0) || (illegal && !TRAP_EN);
    push_noise(mk(3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, nop_like, 1'b0, m_err));
    if (nop_like) return;
    if (op == 4'hF) begin m_stop = 1'b1; m_hst = 3'd5; return; end
    if (illegal) begin m_err = 1'b1; m_stop = 1'b1; m_hst = 3'd6; return; end
    case (op)
      4'h2:    alu = 3'd2;
      4'h3:    alu = 3'd3;
      4'h4:    alu = 3'd4;
      default: alu = 3'd1;
    endcase
    push_noise(mk(3'd2, 1'b0, 1'b0, 1'b0, alu, 1'b0, 1'b0, 1'b0, m_err));
    if (op == 4'h5 || op == 4'h6) begin
      n = (d <= T) ? d + 1 : T + 1;
      for (int unsigned k = 0; k < n; k++)
        push(1'($urandom), 16'($urandom), (k == d),
             mk(3'd3, 1'b0, 1'b1, (op == 4'h6), 3'd0, 1'b0, 1'b0, 1'b0, m_err));
      if (d > T) begin m_err = 1'b1; m_stop = 1'b1; m_hst = 3'd5; return; end
      if (op == 4'h6) begin m_pend = 1'b1; return; end
    end
    push_noise(mk(3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, m_err));
  endtask

  task automatic gen_tail();
    if (m_stop) begin
      for (int i = 0; i < 3; i++)
        push(1'b1, 16'($urandom), 1'($urandom),
             mk(m_hst, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, m_err));
    end else begin
      for (int i = 0; i < 2; i++) push_fetch(1'b0, 16'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("reset_outs", {3'b0, outvec}, '0);
    check("reset_alu_instr", {14'b0, alu_instr}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_err = 1'b0; m_pend = 1'b0; m_stop = 1'b0; m_hst = 3'd5;
    prog.delete();
  endtask

  // Entered at posedge+1; returns at the negedge of the last applied step.
  task automatic run_prog(input int limit);
    for (int i = 0; i < prog.size() && i < limit; i++) begin
      instr_valid = prog[i].valid;
      instr       = prog[i].instr;
      mem_ack     = prog[i].ack;
      @(negedge clk);
      check($sformatf("cyc%0d", ncyc), {3'b0, outvec}, {3'b0, prog[i].exp});
      check("alu_instr", {14'b0, alu_instr}, '0);
      ncyc++;
      if (i + 1 < prog.size() && i + 1 < limit) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    // Directed mix: ALU ops, LD wait 2, ST wait 0, ack on the last allowed cycle, NOP, illegal, timeout.
    do_reset();
    gen_op(4'h1, 0, 0);
    gen_op(4'h2, 0, 1);
    gen_op(4'h3, 0, 0);
    gen_op(4'h4, 0, 2);
    gen_op(4'h5, 2, 0);
    gen_op(4'h6, 0, 0);
    gen_op(4'h6, T, 0);
    gen_op(4'h5, T, 1);
    gen_op(4'h0, 0, 0);
    gen_op(4'h9, 0, 0);
    gen_op(4'h6, T + 5, 0);
    gen_tail();
    run_prog(prog.size());

    // HALT opcode, then instructions offered must be refused.
    do_reset();
    gen_op(4'h1, 0, 0);
    gen_op(4'hF, 0, 0);
    gen_tail();
    run_prog(prog.size());

    // Reset while a load waits in MEM: handshake, DECODE, EXEC, first MEM cycle.
    do_reset();
    gen_op(4'h5, T + 5, 0);
    run_prog(4);
    #2;
    do_reset();
    gen_op(4'h2, 0, 0);
    gen_tail();
    run_prog(prog.size());

    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int j = 0; j < 12; j++)
        gen_op(4'($urandom_range(0, 15)), $urandom_range(0, T + 2), $urandom_range(0, 2));
      gen_tail();
      run_prog(prog.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
